areg_shift: RTL and testbench
=============================

Name: areg_shift

Overview:
- Parametrised successor to the single-bit A-register cell: a W-bit accumulator ("A") register for the bit-serial datapath.
- Parallel load from the data bus; open-drain readback onto the bus.
- A start-triggered serial pass shifts the word LSB-first into the serial ALU while taking result bits back in at the MSB.
- Sits between the shared data bus and the serial ALU; the control sequencer drives wra/rda/start.

Parameters:
- W, 8, register width in bits (W >= 2).
- SHIFTS, W, number of shift cycles per serial pass (1..W).
- RESET_VAL, 0, W-bit value loaded on clr.

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-high reset.
- wra  input  1  parallel-load strobe; captures dbus_in on the next rising clk.
- dbus_in  input  W  bus value as seen by this block (resolved wired-AND bus).
- rda  input  1  read enable for the open-drain bus drive.
- dbus_pd  output  W  per-bit pull-down enable: dbus_pd[i] = rda & ~aout[i]. Combinational; 1 means pull bus bit i low.
- start  input  1  begin a serial pass.
- sin  input  1  serial result bit from the ALU, entering at bit W-1.
- sout  output  1  serial bit to the ALU, equal to aout[0].
- aout  output  W  current register contents.
- busy  output  1  high while a serial pass is in progress.
- done  output  1  one-cycle pulse after the final shift.

Behaviour:
- clr asserted: aout=RESET_VAL, state=IDLE, count=0, busy=0, done=0, immediately and asynchronously. dbus_pd then follows rda & ~RESET_VAL.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - wra=1: aout <= dbus_in.
  - otherwise, start=1: go to SHIFT with count=0.
  - wra and start both high: the load wins and start is ignored; the sequencer must re-issue start.
- SHIFT:
  - Each clk: aout <= {sin, aout[W-1:1]}; count <= count+1.
  - After the SHIFTS-th shift (count == SHIFTS-1 at the edge), go to DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1, busy=0 for exactly one cycle, then IDLE.
  - A load is accepted in DONE exactly as in IDLE. start in DONE is ignored.
- Pass latency: start sampled at edge 0; SHIFTS shift edges follow; done is high in the cycle after the last shift.
- wra and start are ignored while in SHIFT: a load must not corrupt a pass in progress.
- sout is combinational from aout[0], so the ALU sees the bit that will be shifted out at the next edge.
- rda is independent of the FSM: readback is allowed in any state and reflects the current aout.
- Count width is clog2(SHIFTS)+1. It never wraps, because it exits at SHIFTS-1.
- SHIFTS < W: a partial pass; the upper bits take the first sin values.
- clr mid-pass aborts the pass: no done pulse, and the register returns to RESET_VAL.

Optional Feature:
- Macro: AREG_ROTATE_EN.
- Defined:
  - Extra input port rot (1 bit), sampled with start and held for the whole pass.
  - When rot=1, the bit entering at W-1 is aout[0] (rotate) instead of sin. SHIFTS=W then restores the original value.
- Undefined: port rot is absent and the shift-in is always sin.

Decomposition:
- Shared package areg_pkg holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - a clog2 function used for the counter width.
- Natural sub-module areg_stage, one bit, instantiated W times by generate. Each stage holds:
  - a flop with async clr and reset value;
  - a mux selecting hold, load (dbus_in[i]) or shift (left neighbour or sin);
  - the open-drain pull-down term rda & ~q.
- The FSM and counter stay in areg_shift.

Test Plan:
- Reset: W=8, RESET_VAL=8'h00, clr pulse mid-cycle -> aout=00, busy=0, done=0 immediately. With rda=1, dbus_pd=8'hFF.
- Load/readback: wra=1 with dbus_in=8'hA5; after the edge aout=A5. Then rda=1 -> dbus_pd=8'h5A. With rda=0 -> dbus_pd=00.
- Full pass: aout=8'h81, start pulse, sin=1 constant.
  - sout sequence is 1,0,0,0,0,0,0,1.
  - busy is high for 8 cycles; done pulses one cycle later.
  - Final aout=8'hFF.
- Blocked ops: during SHIFT, assert wra with dbus_in=8'h00 and a second start -> both ignored, and the pass result is unchanged.
- Abort and priority:
  - clr at shift 3 of 8 -> aout=00, state IDLE, no done pulse.
  - wra and start asserted together in IDLE -> load only, busy stays 0.
- AREG_ROTATE_EN: aout=8'h3C, rot=1, start -> after 8 shifts aout=3C and done pulses once. With the macro undefined, the same stimulus with sin=0 gives aout=00.

Source files
------------

// File: rtl/areg_pkg.sv
// Shared definitions for the areg_shift accumulator: FSM state encoding and
// a constant-width helper for the shift counter.
package areg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/areg_stage.sv
// One bit of the A register: flop with hold/load/shift select and the
// open-drain pull-down term for bus readback.
import areg_pkg::*;

module areg_stage #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic load,
    input  logic shift,
    input  logic din,
    input  logic shin,
    input  logic rda,
    output logic q,
    output logic pd
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= RESET_BIT;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= shin;
        end
    end

    assign pd = rda & ~q;

endmodule

// File: rtl/areg_shift.sv
// W-bit accumulator register for the bit-serial datapath: parallel load,
// open-drain readback and a start-triggered LSB-first serial pass.
// Optional macro AREG_ROTATE_EN adds port rot to recirculate aout[0] instead of sin.
import areg_pkg::*;

module areg_shift #(
    parameter int             W         = 8,
    parameter int             SHIFTS    = W,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         wra,
    input  logic [W-1:0] dbus_in,
    input  logic         rda,
    output logic [W-1:0] dbus_pd,
`ifdef AREG_ROTATE_EN
    input  logic         rot,
`endif
    input  logic         start,
    input  logic         sin,
    output logic         sout,
    output logic [W-1:0] aout,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = clog2(SHIFTS) + 1;
    localparam logic [CW-1:0] LAST = CW'(SHIFTS - 1);

    state_t        state;
    logic [CW-1:0] count;
    logic          load;
    logic          shift;
    logic          shin;
    logic [W-1:0]  shin_vec;

    // Loads are locked out during a pass so a stray wra cannot corrupt it.
    assign load  = wra && (state != SHIFT);
    assign shift = (state == SHIFT);
    assign sout  = aout[0];

`ifdef AREG_ROTATE_EN
    logic rot_q;
    assign shin = rot_q ? aout[0] : sin;
`else
    assign shin = sin;
`endif

    assign shin_vec = {shin, aout[W-1:1]};

    for (genvar i = 0; i < W; i++) begin : g_bit
        areg_stage #(
            .RESET_BIT(RESET_VAL[i])
        ) u_stage (
            .clk  (clk),
            .clr  (clr),
            .load (load),
            .shift(shift),
            .din  (dbus_in[i]),
            .shin (shin_vec[i]),
            .rda  (rda),
            .q    (aout[i]),
            .pd   (dbus_pd[i])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef AREG_ROTATE_EN
            rot_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // A simultaneous load wins; start must be re-issued.
                    if (!wra && start) begin
                        state <= SHIFT;
                        count <= '0;
                        busy  <= 1'b1;
`ifdef AREG_ROTATE_EN
                        rot_q <= rot;
`endif
                    end
                end
                SHIFT: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_areg_shift.sv
// Directed bench for areg_shift (W=8): table of per-cycle vectors plus
// hand-written sequences for blocked ops, abort, priority and rotate.
module tb_areg_shift;

    logic       clk = 1'b0;
    logic       clr;
    logic       wra;
    logic [7:0] dbus_in;
    logic       rda;
    logic [7:0] dbus_pd;
    logic       rot;
    logic       start;
    logic       sin;
    logic       sout;
    logic [7:0] aout;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    areg_shift #(.W(8), .SHIFTS(8), .RESET_VAL(8'h00)) dut (
        .clk    (clk),
        .clr    (clr),
        .wra    (wra),
        .dbus_in(dbus_in),
        .rda    (rda),
        .dbus_pd(dbus_pd),
`ifdef AREG_ROTATE_EN
        .rot    (rot),
`endif
        .start  (start),
        .sin    (sin),
        .sout   (sout),
        .aout   (aout),
        .busy   (busy),
        .done   (done)
    );

    typedef struct {
        logic       wra;
        logic       rda;
        logic       start;
        logic       sin;
        logic [7:0] dbus;
        logic [7:0] aout;
        logic [7:0] pd;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wra = 1'b0; start = 1'b0; rda = 1'b0; sin = 1'b0; dbus_in = 8'h00; rot = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        wra = 1'b1; dbus_in = v;
        step();
        wra = 1'b0;
    endtask

    logic [7:0] pat;
    int         done_cnt;

    initial begin
        // Per-cycle vectors: inputs applied before the edge, outputs checked after it.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h5A, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 8'h81, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h81, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hC0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE0, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hF0, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hF8, 8'h07, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFC, 8'h00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFE, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};

        idle_inputs();
        clr = 1'b1;
        #12;
        clr = 1'b0;
        step();

        // Asynchronous reset mid-cycle from a non-zero value.
        load(8'h77);
        chk("pre_reset_aout", aout, 8'h77);
        #2;
        rda = 1'b1;
        clr = 1'b1;
        #1;
        chk("reset_aout", aout, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_pd", dbus_pd, 8'hFF);
        clr = 1'b0;
        rda = 1'b0;
        step();

        // Load, readback and a full pass with sin=1.
        for (int i = 0; i < 14; i++) begin
            wra = vecs[i].wra; rda = vecs[i].rda; start = vecs[i].start;
            sin = vecs[i].sin; dbus_in = vecs[i].dbus;
            step();
            chk($sformatf("vec%0d_aout", i), aout, vecs[i].aout);
            chk($sformatf("vec%0d_pd", i), dbus_pd, vecs[i].pd);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_done", i), done, vecs[i].done);
            chk($sformatf("vec%0d_sout", i), sout, vecs[i].aout[0]);
        end
        idle_inputs();
        step();

        // Blocked ops: wra with 00 and a second start during the pass are ignored.
        pat = 8'hB2;
        load(8'h81);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sin = pat[k];
            if (k == 2) begin
                wra = 1'b1; dbus_in = 8'h00; start = 1'b1;
            end
            step();
            wra = 1'b0; start = 1'b0;
            chk($sformatf("blk_busy%0d", k), busy, (k < 7) ? 1'b1 : 1'b0);
            chk($sformatf("blk_done%0d", k), done, (k == 7) ? 1'b1 : 1'b0);
        end
        chk("blk_aout", aout, 8'hB2);
        step();
        chk("blk_done_after", done, 1'b0);
        idle_inputs();

        // Abort: clr during shift 3 of 8.
        load(8'h81);
        sin = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("abort_pre_aout", aout, 8'hF0);
        #2;
        clr = 1'b1;
        #1;
        chk("abort_aout", aout, 8'h00);
        chk("abort_busy", busy, 1'b0);
        clr = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle_aout", aout, 8'h00);
        chk("abort_idle_busy", busy, 1'b0);
        idle_inputs();

        // Priority: load and start together in IDLE.
        wra = 1'b1; start = 1'b1; dbus_in = 8'h3C;
        step();
        wra = 1'b0; start = 1'b0;
        chk("prio_aout", aout, 8'h3C);
        chk("prio_busy", busy, 1'b0);
        step();
        chk("prio_busy2", busy, 1'b0);
        chk("prio_aout2", aout, 8'h3C);

        // Rotate pass from 3C with sin=0.
        rot = 1'b1; sin = 1'b0; start = 1'b1;
        step();
        start = 1'b0; rot = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) done_cnt++;
        end
`ifdef AREG_ROTATE_EN
        chk("rot_aout", aout, 8'h3C);
`else
        chk("rot_aout", aout, 8'h00);
`endif
        chk("rot_done_once", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
